// File: rtl/instr_ahbl_master.sv
// instr_ahbl_master: bridges the core instruction-fetch req/gnt/rvalid interface onto
// single-beat AHB-Lite reads. The address phase of fetch N+1 overlaps the data phase of fetch N,
// with at most one transfer outstanding.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned fetches answered with err, no bus
// transfer issued).
module instr_ahbl_master #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [3:0]  HPROT_VAL  = 4'b0010
) (
   input  logic                  clk,
   input  logic                  rst,
   // core fetch interface
   input  logic                  instr_req,
   input  logic [ADDR_WIDTH-1:0] instr_addr,
   output logic                  instr_gnt,
   output logic                  instr_rvalid,
   output logic [DATA_WIDTH-1:0] instr_rdata,
   output logic                  instr_err,
   // AHB-Lite master
   output logic [ADDR_WIDTH-1:0] ahbl_haddr,
   output logic [1:0]            ahbl_htrans,
   output logic [2:0]            ahbl_hsize,
   output logic [2:0]            ahbl_hburst,
   output logic                  ahbl_hwrite,
   output logic [3:0]            ahbl_hprot,
   output logic                  ahbl_hmastlock,
   output logic [DATA_WIDTH-1:0] ahbl_hwdata,
   input  logic [DATA_WIDTH-1:0] ahbl_hrdata,
   input  logic                  ahbl_hready,
   input  logic                  ahbl_hresp
);

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   // DP_ERR1: first cycle of a two-cycle ERROR seen; DP_LERR: locally rejected fetch pending.
   typedef enum logic [1:0] {DP_NONE, DP_BUSY, DP_ERR1, DP_LERR} dp_state_t;

   dp_state_t dp_state;
   logic      can_issue;
   logic      addr_ok;
   logic      issue;

`ifdef FETCH_MISALIGN_CHK_EN
   assign addr_ok = (instr_addr[1:0] == 2'b00);
`else
   // Low address bits are ignored: every fetch is a word fetch.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^instr_addr[1:0];
   assign addr_ok         = 1'b1;
`endif

   // Address phase: new grants only when the bus is ready and not inside an error response.
   assign can_issue   = ahbl_hready && (dp_state != DP_ERR1) && !rst;
   assign instr_gnt   = instr_req && can_issue;
   assign issue       = instr_gnt && addr_ok;
   assign ahbl_htrans = issue ? HTRANS_NONSEQ : HTRANS_IDLE;

   assign ahbl_haddr     = {instr_addr[ADDR_WIDTH-1:2], 2'b00};
   assign ahbl_hsize     = 3'b010;
   assign ahbl_hburst    = 3'b000;
   assign ahbl_hwrite    = 1'b0;
   assign ahbl_hprot     = HPROT_VAL;
   assign ahbl_hmastlock = 1'b0;
   assign ahbl_hwdata    = '0;

   // Data-phase tracker: advances on ready cycles; ERR1 always completes the error sequence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dp_state <= DP_NONE;
      end else if (ahbl_hready || (dp_state == DP_ERR1)) begin
         if (instr_gnt) begin
            dp_state <= addr_ok ? DP_BUSY : DP_LERR;
         end else begin
            dp_state <= DP_NONE;
         end
      end else if ((dp_state == DP_BUSY) && ahbl_hresp) begin
         dp_state <= DP_ERR1;
      end
   end

   // Response to the core, returned in the cycle the data phase completes.
   always_comb begin
      instr_rvalid = 1'b0;
      instr_err    = 1'b0;
      instr_rdata  = '0;
      if (!rst && ahbl_hready) begin
         unique case (dp_state)
            DP_BUSY: begin
               instr_rvalid = 1'b1;
               // hresp with hready in the first cycle is a protocol violation; report it as error
               instr_err    = ahbl_hresp;
               instr_rdata  = ahbl_hresp ? '0 : ahbl_hrdata;
            end
            DP_ERR1: begin
               instr_rvalid = ahbl_hresp;
               instr_err    = ahbl_hresp;
            end
            DP_LERR: begin
               instr_rvalid = 1'b1;
               instr_err    = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
